// File: rtl/imem_responder.sv
// imem_responder: fixed-latency instruction store responder with stall, flush and load port
module imem_responder #(
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              stall,
  input  logic              flush,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  output logic              rsp_valid,
  output logic [31:0]       rsp_instr,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [2:0]        pending
);
  logic [31:0] mem [2**ADDR_W];
  logic [LATENCY-1:0] v;
  logic [LATENCY-1:0][ADDR_W-1:0] a;
  logic [LATENCY-1:0][31:0] d;
  // store fill; the read below sees the old word on a same-edge write
  always_ff @(posedge clock)
    if (load_en && !reset) mem[load_addr] <= load_data;
  // stage pipeline: shift on accept, hold on stall, flush kills everything but a new request
  always_ff @(posedge clock)
    if (reset) v <= '0;
    else if (!stall) begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        v[i] <= v[i-1] & !flush;
        a[i] <= a[i-1];
        d[i] <= d[i-1];
      end
      v[0] <= req_valid;
      a[0] <= req_addr;
      d[0] <= mem[req_addr];
    end else if (flush) v <= '0;
  // last stage drives the response, zeroed when empty
  always_comb begin
    rsp_valid = v[LATENCY-1];
    rsp_instr = rsp_valid ? d[LATENCY-1] : '0;
    rsp_addr  = rsp_valid ? a[LATENCY-1] : '0;
    pending   = 3'($countones(v));
  end
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed stimulus with a due-cycle scoreboard for imem_responder
module tb_imem_responder;
  localparam int L = 2;
  logic clock = 0, reset = 1, req_valid = 0, stall = 0, flush = 0, load_en = 0;
  logic [11:0] req_addr = 0, load_addr = 0;
  logic [31:0] load_data = 0;
  logic rsp_valid;
  logic [31:0] rsp_instr;
  logic [11:0] rsp_addr;
  logic [2:0] pending;
  typedef struct {int due; logic [11:0] addr; logic [31:0] instr;} ent_t;
  ent_t q[$];
  logic [31:0] shadow [4096];
  int cyc = 0, errors = 0, checks = 0;
  logic mon_en = 0, held = 0, pv = 0;
  logic [31:0] pi = 0;
  logic [11:0] pa = 0;

  imem_responder #(.LATENCY(L), .ADDR_W(12)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .stall(stall), .flush(flush), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .rsp_valid(rsp_valid), .rsp_instr(rsp_instr),
    .rsp_addr(rsp_addr), .pending(pending)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    held <= stall && !flush && !reset;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // output monitor: frozen outputs after a stall edge, otherwise pop and compare
  always @(negedge clock) if (mon_en) begin
    if (held) begin
      chk("frozen_valid", 32'(rsp_valid), 32'(pv));
      chk("frozen_instr", rsp_instr, pi);
      chk("frozen_addr", 32'(rsp_addr), 32'(pa));
    end else if (rsp_valid) begin
      if (q.size() == 0) chk("spurious_valid", 32'(rsp_valid), 0);
      else begin
        ent_t e;
        e = q.pop_front();
        chk("rsp_addr", 32'(rsp_addr), 32'(e.addr));
        chk("rsp_instr", rsp_instr, e.instr);
        chk("rsp_cycle", 32'(cyc), 32'(e.due));
      end
    end else begin
      chk("idle_instr", rsp_instr, 0);
      chk("idle_addr", 32'(rsp_addr), 0);
      if (q.size() != 0 && q[0].due <= cyc) begin
        chk("missing_rsp", 32'(rsp_valid), 1);
        void'(q.pop_front());
      end
    end
    pv <= rsp_valid;
    pi <= rsp_instr;
    pa <= rsp_addr;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [11:0] ad, input logic [31:0] dt);
    load_en = 1; load_addr = ad; load_data = dt;
    tick();
    load_en = 0;
    shadow[ad] = dt;
  endtask

  task automatic req(input logic [11:0] ad);
    req_valid = 1; req_addr = ad;
    tick();
    q.push_back('{cyc + L - 1, ad, shadow[ad]});
  endtask

  task automatic idle(input int n);
    req_valid = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    tick(); tick();
    chk("reset_valid", 32'(rsp_valid), 0);
    chk("reset_instr", rsp_instr, 0);
    chk("reset_addr", 32'(rsp_addr), 0);
    chk("reset_pending", 32'(pending), 0);
    reset = 0;
    mon_en = 1;
    for (int i = 0; i < 4; i++) load(12'(i), 32'hA0 + 32'(i));
    load(12'h020, 32'h11111111);
    load(12'h005, 32'h12345678);
    load(12'hFFF, 32'hCAFEF00D);
    // back-to-back stream
    for (int i = 0; i < 4; i++) req(12'(i));
    idle(3);
    // stall with one entry in flight and the next request held
    req(12'h010);
    stall = 1; req_valid = 1; req_addr = 12'h011;
    for (int i = 0; i < 3; i++) begin
      tick();
      foreach (q[k]) q[k].due++;
      chk("stall_pending", 32'(pending), 1);
    end
    stall = 0;
    req(12'h011);
    idle(3);
    // flush with redirect target
    req(12'h030);
    req(12'h031);
    flush = 1; req_valid = 1; req_addr = 12'h040;
    tick();
    q.delete();
    q.push_back('{cyc + L - 1, 12'h040, shadow[12'h040]});
    chk("flush_pending", 32'(pending), 1);
    flush = 0;
    idle(3);
    // read-before-write on the same address
    load_en = 1; load_addr = 12'h020; load_data = 32'hDEADBEEF;
    req(12'h020);
    load_en = 0;
    shadow[12'h020] = 32'hDEADBEEF;
    req(12'h020);
    idle(3);
    // reset mid-stream with a load that must be ignored
    req(12'h001);
    req(12'h002);
    reset = 1; req_valid = 0; load_en = 1; load_addr = 12'h005; load_data = 32'h55555555;
    tick();
    q.delete();
    chk("midreset_valid", 32'(rsp_valid), 0);
    chk("midreset_instr", rsp_instr, 0);
    chk("midreset_pending", 32'(pending), 0);
    reset = 0; load_en = 0;
    idle(3);
    req(12'h005);
    req(12'hFFF);
    req(12'h000);
    idle(3);
    // flush and stall together: clear, accept nothing
    req(12'h007);
    req(12'h008);
    flush = 1; stall = 1; req_valid = 1; req_addr = 12'h009;
    tick();
    q.delete();
    chk("fs_pending", 32'(pending), 0);
    chk("fs_valid", 32'(rsp_valid), 0);
    flush = 0; stall = 0;
    idle(4);
    chk("queue_drained", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
